// File: rtl/rib_wait_sram_pkg.sv
// Shared definitions for the wait-state RIB SRAM responder: bus widths,
// FSM state encoding and wait counter width.
package rib_wait_sram_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    RWS_IDLE = 2'd0,
    RWS_WAIT = 2'd1,
    RWS_DONE = 2'd2
  } rws_state_e;

endpackage

// File: rtl/rib_sram_array.sv
// Single-port synchronous RAM (DEPTH x 32). Read data is registered and
// only updated on a read strobe, so it holds the last read value.
module rib_sram_array
  import rib_wait_sram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [MemBus-1:0] wdata,
  output logic [MemBus-1:0] rdata
);

  logic [MemBus-1:0] mem [DEPTH];

  // Storage is deliberately not reset; contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/rib_wait_sram.sv
// Wait-state RIB SRAM responder: stalls the initiator via hold_o for
// WAIT_CYCLES extra cycles per access, then commits the access.
module rib_wait_sram
  import rib_wait_sram_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [MemAddrBus-1:0] addr_i,
  input  logic [MemBus-1:0]     data_i,
  output logic [MemBus-1:0]     data_o,
  output logic                  hold_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  rws_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [MemBus-1:0] wdata_q;
  logic              latch, commit;
  logic              c_we;
  logic [AW-1:0]     c_addr;
  logic [MemBus-1:0] c_wdata;
  logic              arr_we, arr_re;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[MemAddrBus-1:AW+2], addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RWS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latches are data only; they are rewritten on every accept.
  always_ff @(posedge clk) begin
    if (latch) begin
      we_q    <= we_i;
      addr_q  <= addr_i[AW+1:2];
      wdata_q <= data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      RWS_IDLE: begin
        if (req_i) begin
          latch = 1'b1;
          cnt_d = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_d = RWS_DONE;
            commit  = 1'b1;
          end else begin
            state_d = RWS_WAIT;
          end
        end
      end
      RWS_WAIT: begin
        if (!req_i) begin
          state_d = RWS_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RWS_DONE;
            commit  = 1'b1;
          end
        end
      end
      RWS_DONE: state_d = RWS_IDLE;
      default:  state_d = RWS_IDLE;
    endcase
  end

  // With zero wait states the commit happens while still in IDLE, before
  // the latches are loaded, so the live inputs are used there.
  assign c_we    = (state_q == RWS_IDLE) ? we_i : we_q;
  assign c_addr  = (state_q == RWS_IDLE) ? addr_i[AW+1:2] : addr_q;
  assign c_wdata = (state_q == RWS_IDLE) ? data_i : wdata_q;

  assign arr_we = commit &  c_we & ~rst;
  assign arr_re = commit & ~c_we & ~rst;

  assign hold_o = req_i & ((state_q == RWS_IDLE) | (state_q == RWS_WAIT));

  rib_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (c_addr),
    .wdata (c_wdata),
    .rdata (data_o)
  );

endmodule

// File: doc/rib_wait_sram.md
# rib_wait_sram

Wait-state RIB bus responder: a word-addressed on-chip SRAM slave that answers the core's data-side requests (`req`/`we`/`addr`/`data`). It stalls the initiator through a hold flag for a programmable number of wait cycles. The hold output is OR-ed into the bus hold signal that feeds the core's `rib_hold_flag_i`. It models slow memory and peripherals and exercises the pipeline stall path.

## Interface
Parameters:
- `DEPTH`, 4096 — number of 32-bit words; power of two.
- `WAIT_CYCLES`, 2 — extra stall cycles per access; 0..15.

Ports:
- `clk`  in  1  — core clock.
- `rst`  in  1  — reset, synchronous and active-high.
- `req_i`  in  1  — access request from initiator.
- `we_i`  in  1  — 1 = write, 0 = read.
- `addr_i`  in  32  — byte address; bits [1:0] ignored.
- `data_i`  in  32  — write data, full word.
- `data_o`  out  32  — read data.
- `hold_o`  out  1  — stall request to initiator.

## Operation
- Word index is `addr_i[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses alias modulo DEPTH*4.
- All accesses are full-word. Byte and halfword stores arrive pre-merged from the initiator.
- FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - `req_i`=1 → latch `we_i`/`addr_i`/`data_i` and load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else DONE.
  - `req_i`=0 → stay in IDLE.
- WAIT:
  - `req_i`=0 → abort to IDLE. No write, `data_o` unchanged.
  - Otherwise decrement the counter. At counter==1 (last WAIT cycle), go to DONE.
  - On that edge, perform the array write (if latched we) or register the array read into `data_o`.
  - With WAIT_CYCLES=0, the commit happens on the IDLE→DONE edge.
- DONE:
  - `hold_o`=0 and `data_o` is valid; the initiator samples and advances.
  - Unconditionally return to IDLE. A `req_i` still high in DONE is not a new request.
- Input changes during WAIT are ignored; only latched values are used.
- `hold_o` = `req_i` & (state==IDLE | state==WAIT). This is combinational, so the stall is asserted in the same cycle the request appears.
- `data_o` changes only on read commit and holds the last read value otherwise. Writes never alter it.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `data_o` = 0, `hold_o` = 0 (given `req_i`=0).
  - Array contents are not reset.
- Request first seen at cycle T:
  - `hold_o`=1 in cycles T..T+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles.
  - DONE in T+WAIT_CYCLES+1, with `hold_o`=0 and read data on `data_o`.
  - IDLE in T+WAIT_CYCLES+2.
- Back-to-back accesses: the next request is accepted no earlier than T+WAIT_CYCLES+2. Throughput is one access per WAIT_CYCLES+2 cycles.
- Write becomes visible to any read committed after the write's DONE cycle.
- `rst` high in any state → IDLE next edge. An uncommitted write is discarded and memory is unchanged.
- Simultaneous `rst` and commit edge: reset wins, no write.

## Structure
- Shared package / defines holds:
  - State encoding (2-bit `RWS_IDLE`/`RWS_WAIT`/`RWS_DONE`).
  - Counter width of 4.
  - Bus widths already defined (`MemAddrBus`, `MemBus`).
- One natural sub-module: `rib_sram_array`, a single-port synchronous RAM (DEPTH×32) with `we`, `addr`, `wdata` and registered `rdata`.
- FSM, counter and latches live in the top.

## Test plan
- Write then read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x0000_0004 → `hold_o` high exactly 3 cycles, DONE on cycle 4.
  - Subsequent read of 0x4 → `data_o`=0xDEADBEEF in its DONE cycle with `hold_o`=0.
- WAIT_CYCLES=0: read request → `hold_o` high 1 cycle, data valid in the next cycle.
- Write abort: drop `req_i` in the 2nd WAIT cycle of a write of 0x12345678 to 0x8 → later read of 0x8 returns the prior value 0x0000_0000.
- Reset mid-WAIT of a read → IDLE next edge, `data_o`=0, `hold_o`=0 with `req_i` low, memory preserved.
- Alias, DEPTH=4096:
  - Write 0xA5A5A5A5 to 0x0000_4000 → read of 0x0000_0000 returns 0xA5A5A5A5.
  - Write to 0x0000_0003 lands at word 0.
- Input change during WAIT: change `addr_i`/`data_i` after T → write commits the latched address/data only; the new address is unchanged.
